instruction_memory_rw: RTL and testbench
========================================

# instruction_memory_rw

Parametrised, loadable instruction memory with a registered fetch port and valid/ready handshake, sitting between the PC/fetch stage and the IF/ID pipeline register. After reset it is held in a LOAD state in which a program loader writes words through a dedicated write port. It then switches to RUN and serves one-cycle-latency fetches with stall, flush, and address-fault reporting.

## Interface
- N, 32: instruction and address width.
- M, 256: depth in words; AW = $clog2(M).
- BYTE_ADDR, 1: 1 means fetch_addr is a byte address and index = fetch_addr[N-1:2]; 0 means word address and index = fetch_addr.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_en  in  1  loader write strobe; honoured in LOAD only.
- ld_addr  in  AW  loader word index.
- ld_data  in  N  loader write data.
- ld_done  in  1  loader finished; causes LOAD to RUN.
- loading  out  1  high in LOAD.
- ld_count  out  AW+1  number of writes accepted since reset, saturating at M.
- fetch_valid  in  1  fetch request.
- fetch_addr  in  N  fetch address.
- fetch_ready  out  1  request accepted this cycle when high together with fetch_valid.
- flush  in  1  discard the held output instruction (branch taken).
- instr_valid  out  1  instr and fault are valid.
- instr  out  N  fetched instruction.
- instr_ready  in  1  downstream accepts instr.
- fault  out  2  2'b00 none, 2'b01 misaligned, 2'b10 out of range.

## Operation
- **States**
  - LOAD: entered on rst.
  - RUN: entered on the clock edge where ld_done=1 in LOAD.
  - RUN to LOAD happens only via rst.
- **LOAD**
  - fetch_ready=0.
  - ld_en=1 writes mem[ld_addr] <= ld_data and increments ld_count (saturating at M).
  - ld_en and ld_done in the same cycle: the write is performed, then the block moves to RUN.
- **RUN**
  - ld_en and ld_done are ignored; memory is read-only.
  - fetch_ready = !instr_valid || instr_ready.
  - On accept (fetch_valid && fetch_ready) the output register loads, next edge:
    - instr = mem[index];
    - fault = 00;
    - instr_valid = 1.
- **Faults**
  - Misaligned: BYTE_ADDR=1 and fetch_addr[1:0] != 0. Gives fault=01 and instr=NOP (32'h00000013).
  - Out of range: index >= M. Gives fault=10 and instr=NOP.
  - Misaligned has priority over out of range.
  - A faulting fetch still produces instr_valid=1.
- **Hold**
  - With instr_valid && !instr_ready, instr and fault stay stable.
  - No new request is accepted while holding.
- **Handoff**
  - With instr_valid && instr_ready && no accept, instr_valid clears next edge.
- **Flush**
  - flush=1 with no accept: instr_valid clears next edge.
  - flush=1 with accept in the same cycle: the new fetch is loaded; the held word is dropped.
  - While the output is stalled, fetch_ready must be computed as !instr_valid || instr_ready || flush.
- **Memory contents** are not affected by rst.

## Timing
- Fetch latency is 1 cycle: a request accepted at edge k gives instr_valid=1 after edge k.
- Back-to-back throughput is 1 instruction per cycle when instr_ready=1.
- Reset values (asynchronous):
  - loading=1, ld_count=0;
  - instr_valid=0, instr=NOP, fault=00;
  - fetch_ready=0.
- rst mid-transfer drops any held instruction immediately; the loader must reload.
- fetch_ready is combinational from state, instr_valid, instr_ready and flush.
- No combinational path from fetch_addr to instr.

## Structure
- Shared package riscv_pkg holds:
  - the NOP constant 32'h00000013;
  - fault code localparams FLT_NONE, FLT_MISALIGN, FLT_RANGE;
  - the state encoding ST_LOAD, ST_RUN.
- One sub-module, imem_array: M x N storage with synchronous write and registered read.
- The top level contains the state register, ld_count, fault decode, and the output/handshake register.

## Test plan
- Reset, load mem[0..3] = 0x002081B3, 0x40208233, 0x0020F2B3, 0x0020E333, then ld_done -> loading=0, ld_count=4; fetch byte addresses 0,4,8,12 with instr_ready=1 -> those four words on consecutive cycles, fault=00.
- fetch_valid=1 during LOAD -> fetch_ready=0 and no instr_valid; ld_en in RUN with ld_addr=0, ld_data=0 -> a later fetch of 0 still returns 0x002081B3.
- Fetch addr 6 -> instr=0x00000013, fault=01; fetch addr 4*M -> instr=0x00000013, fault=10; fetch addr 4*M+2 -> fault=01.
- instr_ready=0 for 3 cycles after fetch of addr 4 -> instr held at 0x40208233, fetch_ready=0; release -> next request accepted the same cycle.
- Stalled output plus flush=1 with a fetch of addr 12 -> next cycle instr=0x0020E333; flush with no fetch -> instr_valid=0.
- rst asserted mid-stream -> instr_valid=0 and loading=1 immediately; 300 ld_en writes with M=256 -> ld_count saturates at 256.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the fetch path: NOP encoding, fetch fault codes and
// the loader/run state encoding.
package riscv_pkg;

  localparam logic [31:0] NOP = 32'h00000013;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_RANGE    = 2'b10;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/imem_array.sv
// M x N word storage with a synchronous write port and a registered read port.
// Writes (loader) and reads (fetch) never overlap because they belong to
// different top-level states.
module imem_array #(
  parameter int N  = 32,
  parameter int M  = 256,
  parameter int AW = $clog2(M)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [M];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read data only moves on an accepted fetch, so a stalled output stays put.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instruction_memory_rw.sv
// Loadable instruction memory: loader fills it in LOAD, then it serves
// one-cycle-latency fetches with stall, flush and address-fault reporting.
module instruction_memory_rw
  import riscv_pkg::*;
#(
  parameter int N         = 32,
  parameter int M         = 256,
  parameter int BYTE_ADDR = 1,
  localparam int AW       = $clog2(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_data,
  input  logic          ld_done,
  output logic          loading,
  output logic [AW:0]   ld_count,
  input  logic          fetch_valid,
  input  logic [N-1:0]  fetch_addr,
  output logic          fetch_ready,
  input  logic          flush,
  output logic          instr_valid,
  output logic [N-1:0]  instr,
  input  logic          instr_ready,
  output logic [1:0]    fault
);

  localparam int IW = (BYTE_ADDR != 0) ? N - 2 : N;

  state_t        state, state_nx;
  logic          accept;
  logic          run;
  logic [IW-1:0] index;
  logic          misaligned;
  logic          out_of_range;
  logic [1:0]    fault_d;
  logic          nop_sel;
  logic [N-1:0]  rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    loading  = 1'b0;
    run      = 1'b0;
    case (state)
      ST_LOAD: begin
        loading = 1'b1;
        if (ld_done) state_nx = ST_RUN;
      end
      ST_RUN: run = 1'b1;
      default: state_nx = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_count <= '0;
    end else if (loading && ld_en && (ld_count != (AW+1)'(M))) begin
      ld_count <= ld_count + (AW+1)'(1);
    end
  end

  generate
    if (BYTE_ADDR != 0) begin : g_byte
      assign index      = fetch_addr[N-1:2];
      assign misaligned = (fetch_addr[1:0] != 2'b00);
    end else begin : g_word
      assign index      = fetch_addr;
      assign misaligned = 1'b0;
    end
  endgenerate

  assign out_of_range = ({1'b0, index} >= (IW+1)'(M));

  always_comb begin
    fault_d = FLT_NONE;
    if (misaligned)        fault_d = FLT_MISALIGN;
    else if (out_of_range) fault_d = FLT_RANGE;
  end

  // Handshake: a request transfers on any edge where fetch_valid && fetch_ready;
  // the output transfers where instr_valid && instr_ready. A flush frees the
  // output slot so a fetch can be accepted over a stalled word.
  assign fetch_ready = run && (!instr_valid || instr_ready || flush);
  assign accept      = fetch_valid && fetch_ready;

  imem_array #(.N(N), .M(M), .AW(AW)) u_array (
    .clk   (clk),
    .we    (loading && ld_en),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (accept),
    .raddr (index[AW-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid <= 1'b0;
      fault       <= FLT_NONE;
      nop_sel     <= 1'b1;
    end else if (accept) begin
      instr_valid <= 1'b1;
      fault       <= fault_d;
      nop_sel     <= (fault_d != FLT_NONE);
    end else if (instr_ready || flush) begin
      instr_valid <= 1'b0;
    end
  end

  // Faulting fetches and the reset value both present the NOP encoding.
  assign instr = nop_sel ? N'(NOP) : rd_data;

endmodule

// File: tb/tb_instruction_memory_rw.sv
// Self-checking bench for instruction_memory_rw: loader, fetch stream, faults,
// stall, flush, mid-stream reset and ld_count saturation.
module tb_instruction_memory_rw;

  localparam logic [31:0] NOP_W = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_done = 1'b0;
  logic        loading;
  logic [8:0]  ld_count;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        flush = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready = 1'b0;
  logic [1:0]  fault;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic running = 1'b0;
  logic [31:0] model_mem [256];
  logic [33:0] exp_q [$];

  instruction_memory_rw #(.N(32), .M(256), .BYTE_ADDR(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_done     (ld_done),
    .loading     (loading),
    .ld_count    (ld_count),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] model(input logic [31:0] a);
    if (a[1:0] != 2'b00) return {2'b01, NOP_W};
    if ((a >> 2) >= 32'd256) return {2'b10, NOP_W};
    return {2'b00, model_mem[a[9:2]]};
  endfunction

  task automatic load_word(input logic [7:0] a, input logic [31:0] d, input logic done);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d; ld_done = done;
    if (!running) begin
      model_mem[a] = d;
      if (exp_count < 256) exp_count++;
    end
    @(posedge clk);
    if (done) running = 1'b1;
    #1;
    ld_en = 1'b0; ld_done = 1'b0;
  endtask

  // One cycle of fetch-side stimulus; checks what the DUT presents before the edge.
  task automatic step(input logic fv, input logic [31:0] a, input logic rdy, input logic fl);
    logic exp_ready;
    logic [33:0] e;
    @(negedge clk);
    fetch_valid = fv; fetch_addr = a; instr_ready = rdy; flush = fl;
    #1;
    exp_ready = running && (exp_q.size() == 0 || rdy || fl);
    checks++;
    if (instr_valid !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL instr_valid: got %b want %b", instr_valid, exp_q.size() != 0);
    end
    checks++;
    if (fetch_ready !== exp_ready) begin
      errors++;
      $display("FAIL fetch_ready: got %b want %b", fetch_ready, exp_ready);
    end
    if (exp_q.size() != 0) begin
      if (rdy) begin
        e = exp_q.pop_front();
        checks++;
        if ({fault, instr} !== e) begin
          errors++;
          $display("FAIL fetch_data: got fault=%b instr=%h want fault=%b instr=%h",
                   fault, instr, e[33:32], e[31:0]);
        end
      end else if (fl) begin
        void'(exp_q.pop_front());
      end
    end
    if (fv && exp_ready) exp_q.push_back(model(a));
  endtask

  task automatic test_reset();
    fetch_valid = 1'b1;
    #1 rst = 1'b1;
    #2;
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL reset_loading: got %b want 1", loading); end
    checks++; if (ld_count !== 9'd0) begin errors++; $display("FAIL reset_ld_count: got %0d want 0", ld_count); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== NOP_W) begin errors++; $display("FAIL reset_instr: got %h want %h", instr, NOP_W); end
    checks++; if (fault !== 2'b00) begin errors++; $display("FAIL reset_fault: got %b want 00", fault); end
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL reset_fetch_ready: got %b want 0", fetch_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; fetch_valid = 1'b0;
  endtask

  task automatic test_load();
    load_word(8'd0, 32'h002081B3, 1'b0);
    load_word(8'd1, 32'h40208233, 1'b0);
    load_word(8'd2, 32'h0020F2B3, 1'b0);
    step(1'b1, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    load_word(8'd3, 32'h0020E333, 1'b1);
    @(negedge clk);
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL load_loading: got %b want 0", loading); end
    checks++; if (ld_count !== 9'(exp_count)) begin errors++; $display("FAIL load_ld_count: got %0d want %0d", ld_count, exp_count); end
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 4; i++) step(1'b1, 32'(4 * i), 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_run_write();
    load_word(8'd0, 32'h00000000, 1'b0);
    @(negedge clk);
    checks++; if (ld_count !== 9'(exp_count)) begin errors++; $display("FAIL run_write_count: got %0d want %0d", ld_count, exp_count); end
    step(1'b1, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_faults();
    step(1'b1, 32'd6, 1'b1, 1'b0);
    step(1'b1, 32'd1024, 1'b1, 1'b0);
    step(1'b1, 32'd1026, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_stall();
    step(1'b1, 32'd4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'd12, 1'b0, 1'b0);
      checks++;
      if (instr !== 32'h40208233) begin
        errors++;
        $display("FAIL stall_hold: got %h want 40208233", instr);
      end
    end
    step(1'b1, 32'd8, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    step(1'b1, 32'd4, 1'b1, 1'b0);
    step(1'b1, 32'd12, 1'b0, 1'b1);
    step(1'b1, 32'd8, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 32'd0, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", instr_valid); end
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL midrst_loading: got %b want 1", loading); end
    exp_q.delete();
    running = 1'b0;
    exp_count = 0;
    @(negedge clk);
    rst = 1'b0; fetch_valid = 1'b0;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) load_word(8'(i % 256), $urandom, (i == 299) ? 1'b1 : 1'b0);
    @(negedge clk);
    checks++; if (ld_count !== 9'd256) begin errors++; $display("FAIL saturate_count: got %0d want 256", ld_count); end
    step(1'b1, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_fetch();
    test_run_write();
    test_faults();
    test_stall();
    test_flush();
    test_reset_mid();
    test_saturate();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
